// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the pipelined ALU. Provides the operation
//               code enum, the control FSM state enum, and a helper that
//               derives the result width from the operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_MUL   = 3'b010,
        OP_DIV   = 3'b011,
        OP_LOR   = 3'b100,
        OP_LAND  = 3'b101,
        OP_COMP  = 3'b110,
        OP_SHIFT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,   // no result held
        DIVB = 2'b01,   // divider iterating
        DONE = 2'b10    // result held, out_valid asserted
    } state_e;

    // Result width is always twice the operand width.
    function automatic int res_width(input int n);
        return 2 * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Command/result bus of the pipelined ALU.
//               Request side : in_valid, in_ready, op_code, inp1, inp2
//               Result side  : out_valid, out_ready, outp, flag_zero,
//                              flag_neg, flag_err
//               master = command driver / result consumer, slave = ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = res_width(N);

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op_code;
    logic [N-1:0]     inp1;
    logic [N-1:0]     inp2;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     outp;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_err;

    modport master (
        output in_valid, op_code, inp1, inp2, out_ready,
        input  in_ready, out_valid, outp, flag_zero, flag_neg, flag_err
    );

    modport slave (
        input  in_valid, op_code, inp1, inp2, out_ready,
        output in_ready, out_valid, outp, flag_zero, flag_neg, flag_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module      : alu_divider
// Description : N-cycle restoring divider, one quotient bit per cycle.
//               The first iteration is performed on the start edge directly
//               from the dividend/divisor inputs, so quotient/remainder are
//               final in the cycle where done pulses (N cycles after start).
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start               - begin a division (divisor must be != 0)
//               dividend, divisor   - operands, sampled on the start edge
//               busy                - iterations still outstanding
//               done                - one-cycle pulse, results valid
//               quotient, remainder - division results
// Revision    : 1.0 - initial release
// ============================================================================
module alu_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int            CW        = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);

    logic [N-1:0]  rem_q, quo_q, dvs_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;

    // Operand sources for this cycle's iteration: fresh inputs on start,
    // otherwise the partial results carried in the registers.
    logic [N-1:0] rem_src, quo_src, dvs_src;
    logic [N:0]   partial, diff;
    logic         fit;
    logic [N-1:0] rem_d, quo_d;

    always_comb begin
        rem_src = start ? '0       : rem_q;
        quo_src = start ? dividend : quo_q;
        dvs_src = start ? divisor  : dvs_q;
        partial = {rem_src, quo_src[N-1]};
        diff    = partial - {1'b0, dvs_src};
        // No borrow out of the subtraction means partial >= divisor.
        fit     = ~diff[N];
        rem_d   = fit ? diff[N-1:0] : partial[N-1:0];
        quo_d   = {quo_src[N-2:0], fit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                dvs_q  <= divisor;
                cnt_q  <= CNT_INIT;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Eight-operation ALU with valid/ready handshakes, a multi-cycle
//               divider and status flags. Single-cycle ops are registered on
//               the accept edge; DIV with a non-zero divisor runs N cycles in
//               alu_divider. The held result is stable until it is taken.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               bus   - alu_pipe_if slave: in_valid/in_ready, op_code,
//                       inp1, inp2, out_valid/out_ready, outp, flag_zero,
//                       flag_neg, flag_err
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      reset,
    alu_pipe_if.slave bus
);

    localparam int W = res_width(N);

    state_e       state_q, state_d;
    logic [W-1:0] outp_q, outp_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
    logic         err_q, err_d;

    op_e          op;
    logic         accept;
    logic         div_start;
    logic         div_busy;
    logic         div_done;
    logic [N-1:0] div_quo, div_rem;

    logic [W-1:0] a_ext, b_ext;
    logic [W-1:0] alu_res;
    logic         alu_neg, alu_err;

    assign op        = op_e'(bus.op_code);
    assign accept    = bus.in_valid && bus.in_ready;
    assign div_start = accept && (op == OP_DIV) && (bus.inp2 != '0);
    assign a_ext     = {{N{1'b0}}, bus.inp1};
    assign b_ext     = {{N{1'b0}}, bus.inp2};

    // Single-cycle datapath. The DIV arm only matters for a zero divisor;
    // non-zero divisors are routed to the sequential divider instead.
    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB: begin
                if (bus.inp2 > bus.inp1) begin
                    alu_res = b_ext - a_ext;
                    alu_neg = 1'b1;
                end else begin
                    alu_res = a_ext - b_ext;
                end
            end
            OP_MUL:   alu_res = a_ext * b_ext;
            OP_DIV: begin
                alu_res = {bus.inp1, {N{1'b1}}};
                alu_err = (bus.inp2 == '0);
            end
            OP_LOR:   alu_res = {{N{1'b0}}, bus.inp1 | bus.inp2};
            OP_LAND:  alu_res = {{N{1'b0}}, bus.inp1 & bus.inp2};
            OP_COMP:  alu_res = {{(W-1){1'b0}}, bus.inp1 == bus.inp2};
            OP_SHIFT: alu_res = {bus.inp1[N-2:0], 1'b0, 1'b0, bus.inp2[N-1:1]};
        endcase
    end

    alu_divider #(
        .N (N)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (bus.inp1),
        .divisor   (bus.inp2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Next-state and result-register logic. Registers hold by default so a
    // stalled result stays bit-stable in DONE.
    always_comb begin
        state_d = state_q;
        outp_d  = outp_q;
        neg_d   = neg_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (div_start) begin
                        state_d = DIVB;
                    end else begin
                        state_d = DONE;
                        outp_d  = alu_res;
                        neg_d   = alu_neg;
                        err_d   = alu_err;
                    end
                end else if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            DIVB: begin
                if (div_done) begin
                    state_d = DONE;
                    outp_d  = {div_rem, div_quo};
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (!div_busy) begin
                    // Divider lost its operation; drop back rather than hang.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (outp_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            outp_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            outp_q  <= outp_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.outp      = outp_q;
    assign bus.flag_zero = zero_q;
    assign bus.flag_neg  = neg_q;
    assign bus.flag_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe. Directed scenarios plus
//               randomized operations on an N=4 instance, one ADD on an N=8
//               instance. Expected values come from an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_pipe_if #(.N(4)) bus4 ();
    alu_pipe_if #(.N(8)) bus8 ();

    alu_pipe #(.N(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    alu_pipe #(.N(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Behavioural model: operation semantics in plain arithmetic.
    function automatic void ref_model(input int n, input logic [2:0] op,
                                      input longint unsigned a, input longint unsigned b,
                                      output longint unsigned res,
                                      output logic neg, output logic err);
        longint unsigned base;
        base = 64'd1 << n;
        neg  = 1'b0;
        err  = 1'b0;
        case (op)
            3'd0: res = a + b;
            3'd1: begin
                if (b > a) begin res = b - a; neg = 1'b1; end
                else res = a - b;
            end
            3'd2: res = a * b;
            3'd3: begin
                if (b == 0) begin res = a * base + (base - 1); err = 1'b1; end
                else res = (a % b) * base + (a / b);
            end
            3'd4: res = a | b;
            3'd5: res = a & b;
            3'd6: res = (a == b) ? 64'd1 : 64'd0;
            default: res = ((a * 2) % base) * base + (b / 2);
        endcase
    endfunction

    // One complete transaction on the N=4 instance, with optional stall.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b, input int stall);
        longint unsigned exp_res;
        logic            exp_neg, exp_err;
        int              lat;
        ref_model(4, op, 64'(a), 64'(b), exp_res, exp_neg, exp_err);
        lat = (op == 3'd3 && b != 4'd0) ? 4 : 0;
        check_bit($sformatf("%s.ready_before", tag), bus4.in_ready, 1'b1);
        bus4.in_valid  = 1'b1;
        bus4.op_code   = op;
        bus4.inp1      = a;
        bus4.inp2      = b;
        bus4.out_ready = 1'b1;
        tick();
        // Scramble inputs: captured operands must not be affected.
        bus4.in_valid = 1'b0;
        bus4.op_code  = 3'($urandom_range(7, 0));
        bus4.inp1     = 4'($urandom);
        bus4.inp2     = 4'($urandom);
        for (int i = 0; i < lat; i++) begin
            check_bit($sformatf("%s.busy_valid[%0d]", tag, i), bus4.out_valid, 1'b0);
            check_bit($sformatf("%s.busy_ready[%0d]", tag, i), bus4.in_ready, 1'b0);
            tick();
        end
        check_bit($sformatf("%s.out_valid", tag), bus4.out_valid, 1'b1);
        check_val($sformatf("%s.outp", tag), 64'(bus4.outp), exp_res);
        check_bit($sformatf("%s.zero", tag), bus4.flag_zero, exp_res == 0);
        check_bit($sformatf("%s.neg", tag), bus4.flag_neg, exp_neg);
        check_bit($sformatf("%s.err", tag), bus4.flag_err, exp_err);
        if (stall > 0) begin
            bus4.out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                check_bit($sformatf("%s.stall_valid[%0d]", tag, i), bus4.out_valid, 1'b1);
                check_val($sformatf("%s.stall_outp[%0d]", tag, i), 64'(bus4.outp), exp_res);
                check_bit($sformatf("%s.stall_ready[%0d]", tag, i), bus4.in_ready, 1'b0);
            end
            bus4.out_ready = 1'b1;
            #1;
        end
        check_bit($sformatf("%s.ready_retire", tag), bus4.in_ready, 1'b1);
        tick();
        check_bit($sformatf("%s.retired", tag), bus4.out_valid, 1'b0);
    endtask

    logic [2:0] bb_op [4];
    logic [3:0] bb_a  [4];
    logic [3:0] bb_b  [4];

    initial begin
        longint unsigned exp_res;
        logic            exp_neg, exp_err;
        checks   = 0;
        failures = 0;

        reset          = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.op_code   = 3'd0;
        bus4.inp1      = 4'd0;
        bus4.inp2      = 4'd0;
        bus4.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.op_code   = 3'd0;
        bus8.inp1      = 8'd0;
        bus8.inp2      = 8'd0;
        bus8.out_ready = 1'b1;
        tick();
        tick();

        // Reset state.
        check_bit("rst.out_valid", bus4.out_valid, 1'b0);
        check_val("rst.outp", 64'(bus4.outp), 64'd0);
        check_bit("rst.zero", bus4.flag_zero, 1'b0);
        check_bit("rst.neg", bus4.flag_neg, 1'b0);
        check_bit("rst.err", bus4.flag_err, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("rst.in_ready", bus4.in_ready, 1'b1);

        // Directed scenarios.
        run_op("add15_15", 3'd0, 4'd15, 4'd15, 0);
        run_op("div13_4",  3'd3, 4'd13, 4'd4,  0);
        run_op("div9_0",   3'd3, 4'd9,  4'd0,  0);
        run_op("sub3_9",   3'd1, 4'd3,  4'd9,  0);
        run_op("sub5_5",   3'd1, 4'd5,  4'd5,  0);
        run_op("mul15_15", 3'd2, 4'd15, 4'd15, 3);
        run_op("div15_1",  3'd3, 4'd15, 4'd1,  1);

        // Back-to-back single-cycle ops, one result per cycle.
        bb_op = '{3'd5, 3'd4, 3'd6, 3'd7};
        bb_a  = '{4'hC, 4'hC, 4'h5, 4'h9};
        bb_b  = '{4'hA, 4'hA, 4'h5, 4'h6};
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_bit($sformatf("b2b.ready[%0d]", k), bus4.in_ready, 1'b1);
            bus4.in_valid = 1'b1;
            bus4.op_code  = bb_op[k];
            bus4.inp1     = bb_a[k];
            bus4.inp2     = bb_b[k];
            tick();
            ref_model(4, bb_op[k], 64'(bb_a[k]), 64'(bb_b[k]), exp_res, exp_neg, exp_err);
            check_bit($sformatf("b2b.valid[%0d]", k), bus4.out_valid, 1'b1);
            check_val($sformatf("b2b.outp[%0d]", k), 64'(bus4.outp), exp_res);
        end
        bus4.in_valid = 1'b0;
        tick();
        check_bit("b2b.drain", bus4.out_valid, 1'b0);

        // Reset on the second DIVB cycle aborts the division.
        bus4.in_valid = 1'b1;
        bus4.op_code  = 3'd3;
        bus4.inp1     = 4'd15;
        bus4.inp2     = 4'd2;
        tick();
        bus4.in_valid = 1'b0;
        check_bit("abort.divb_ready", bus4.in_ready, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check_bit("abort.out_valid", bus4.out_valid, 1'b0);
        check_val("abort.outp", 64'(bus4.outp), 64'd0);
        check_bit("abort.in_ready", bus4.in_ready, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_bit($sformatf("abort.no_stale[%0d]", i), bus4.out_valid, 1'b0);
        end

        // Randomized operations against the model.
        for (int r = 0; r < 40; r++) begin
            logic [2:0] rop;
            logic [3:0] ra, rb;
            rop = 3'($urandom_range(7, 0));
            ra  = 4'($urandom);
            rb  = ($urandom_range(7, 0) == 0) ? 4'd0 : 4'($urandom);
            run_op($sformatf("rnd%0d", r), rop, ra, rb, int'($urandom_range(2, 0)));
        end

        // Wider instance.
        bus8.in_valid = 1'b1;
        bus8.op_code  = 3'd0;
        bus8.inp1     = 8'd255;
        bus8.inp2     = 8'd255;
        tick();
        bus8.in_valid = 1'b0;
        ref_model(8, 3'd0, 64'd255, 64'd255, exp_res, exp_neg, exp_err);
        check_bit("n8.add.valid", bus8.out_valid, 1'b1);
        check_val("n8.add.outp", 64'(bus8.outp), exp_res);
        check_bit("n8.add.zero", bus8.flag_zero, 1'b0);
        tick();
        check_bit("n8.add.retired", bus8.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit registered ALU.
- Same eight-op set. Adds:
  - valid/ready handshakes on input and output;
  - a multi-cycle sequential divider that returns both quotient and remainder;
  - status flags (zero, neg, err) and output backpressure.
- Sits between the command driver and the result scoreboard path. Each instance processes one operation at a time.

Parameters:
- N, 8, operand width in bits (legal values 2..32); result width is 2N.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation this cycle.
- op_code  in  3  operation select: ADD=000, SUB=001, MUL=010, DIV=011, LOR=100, LAND=101, COMP=110, SHIFT=111.
- inp1  in  N  operand A.
- inp2  in  N  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- outp  out  2N  result.
- flag_zero  out  1  outp == 0.
- flag_neg  out  1  SUB only: inp2 > inp1.
- flag_err  out  1  DIV only: inp2 == 0.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - out_valid=0, outp=0, all flags=0, FSM=IDLE.
  - in_ready=1 in the first cycle after reset is released.
- Accept: in_valid && in_ready at a clk edge. op_code, inp1 and inp2 are captured on that edge; later input changes have no effect.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives one-per-cycle throughput for single-cycle ops when the output is not stalled.
- FSM states:
  - IDLE: no result held.
  - DIVB: divider iterating.
  - DONE: result held, out_valid=1.
- FSM transitions:
  - IDLE/DONE, accept non-DIV op, or DIV with inp2==0 → DONE. Result is registered on the accept edge, so out_valid=1 in the next cycle (latency 1).
  - IDLE/DONE, accept DIV with inp2!=0 → DIVB. Restoring division, one quotient bit per cycle for N cycles. Then → DONE. out_valid rises N+1 cycles after the accept edge. in_ready=0 throughout DIVB.
  - DONE, out_ready=1 and no accept → IDLE; out_valid=0 next cycle.
  - DONE, out_ready=0 → stay in DONE. outp and flags must stay bit-stable until the handshake completes.
- Result formats (outp is 2N bits, zero-extended unless stated):
  - ADD: inp1+inp2, carry kept in bit N.
  - SUB: |inp1-inp2|; flag_neg=1 iff inp2>inp1.
  - MUL: full 2N-bit product.
  - DIV: {remainder[N-1:0], quotient[N-1:0]}.
  - DIV with inp2==0: quotient = all ones, remainder = inp1, flag_err=1, latency 1.
  - LOR: inp1|inp2.
  - LAND: inp1&inp2.
  - COMP: 1 if inp1==inp2, else 0.
  - SHIFT: {inp1<<1 truncated to N bits, inp2>>1}.
- flag_zero is computed on the registered outp and is valid while out_valid=1. flag_neg and flag_err are 0 for ops other than SUB and DIV respectively.
- Reset mid-operation: reset during DIVB or DONE aborts the operation. The result is discarded (never presented), and reset values apply on the next edge.
- Simultaneous events: in DONE, out_ready=1 together with in_valid=1 retires the old result and accepts the new op on the same edge. No bubble occurs for non-DIV ops.
- No X on outputs at any time after the first reset.

Decomposition:
- Package alu_pkg holds:
  - op_e enum (3-bit op codes above);
  - state_e enum (IDLE, DIVB, DONE);
  - a localparam helper for result width 2N.
- Sub-module alu_divider (parameter N) holds:
  - inputs: start, dividend, divisor;
  - outputs: busy, done pulse, quotient, remainder;
  - behaviour: N-cycle restoring divider, synchronous reset, abortable by reset.
- Single-cycle ops are combinational logic inside alu_pipe, registered into the output register.

Test Plan (run with N=4 override unless noted):
- ADD 15+15, out_ready=1 → out_valid one cycle after accept; outp=8'h1E, flag_zero=0.
- DIV 13/4 → in_ready=0 for 4 cycles; out_valid at accept+5; outp=8'h13 ({rem=1, quo=3}); flag_err=0.
- DIV 9/0 → latency 1; outp=8'h9F; flag_err=1. Also SUB 3-9 → outp=8'h06, flag_neg=1.
- MUL 15*15 with out_ready held 0 for 3 cycles → outp=8'hE1 stable throughout; in_ready=0; retires when out_ready=1.
- Back-to-back LAND 4'hC&4'hA, LOR 4'hC|4'hA, COMP 5==5, SHIFT(4'h9, 4'h6), with out_ready=1 → one result per cycle: 8'h08, 8'h0E, 8'h01, 8'h23.
- Reset asserted on the 2nd DIVB cycle of 15/2 → next cycle out_valid=0, outp=0, in_ready=1; no stale result appears later. Repeat the ADD test with N=8: 255+255 → outp=16'h01FE.
